// File: rtl/status_flag_controller.sv
// status_flag_controller
// Holds ALU condition flags (replaced on update) and sticky exception flags
// (OR-accumulated). A trap FSM pushes both flag sets onto a shadow stack on trap
// entry and pops them on trap return. Nesting past the stack depth latches a
// double fault that only reset clears.
//
// Ports:
//   clock, reset_n          : clock (rising edge), async active-low reset
//   cond_valid, cond_in     : load new condition flags
//   exc_event               : one-cycle exception pulses, OR'd into sticky flags
//   trap_instruction        : software trap request pulse
//   trap_return             : return from current trap level
//   sw_write, sw_wdata      : software overwrite of {exc, cond}
//   cond_flags, exc_flags   : live flag registers
//   trap_mode               : depth > 0 or double-faulted
//   trap_entry              : one-cycle pulse per accepted trap
//   trap_cause              : 0 = trap_instruction, i+1 = exception bit i
//   trap_depth              : current nesting level
//   double_fault            : sticky stack-overflow indicator
module status_flag_controller #(
    parameter int unsigned COND_W       = 4,
    parameter int unsigned EXC_W        = 8,
    parameter logic [EXC_W-1:0] TRAP_MASK = 8'h0C,
    parameter int unsigned SHADOW_DEPTH = 4,
    localparam int unsigned CW          = $clog2(EXC_W + 1),
    localparam int unsigned DW          = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cond_valid,
    input  logic [COND_W-1:0]       cond_in,
    input  logic [EXC_W-1:0]        exc_event,
    input  logic                    trap_instruction,
    input  logic                    trap_return,
    input  logic                    sw_write,
    input  logic [COND_W+EXC_W-1:0] sw_wdata,
    output logic [COND_W-1:0]       cond_flags,
    output logic [EXC_W-1:0]        exc_flags,
    output logic                    trap_mode,
    output logic                    trap_entry,
    output logic [CW-1:0]           trap_cause,
    output logic [DW-1:0]           trap_depth,
    output logic                    double_fault
);

    typedef enum logic [1:0] {StNormal, StTrapped, StFault} state_e;

    state_e                      state_q, state_d;
    logic [COND_W-1:0]           cond_q, cond_d;
    logic [EXC_W-1:0]            exc_q, exc_d;
    logic [DW-1:0]               depth_q, depth_d;
    logic                        entry_q, entry_d;
    logic [CW-1:0]               cause_q, cause_d;
    logic                        dfault_q, dfault_d;
    logic [COND_W+EXC_W-1:0]     stack_q [SHADOW_DEPTH];
    logic [COND_W+EXC_W-1:0]     stack_d [SHADOW_DEPTH];

    logic [EXC_W-1:0]            masked;
    logic                        req, do_entry, do_overflow, do_pop;
    logic [CW-1:0]               req_cause;
    logic [COND_W+EXC_W-1:0]     popped;

    always_comb begin
        masked = exc_event & TRAP_MASK;
        req    = trap_instruction | (|masked);

        // Scan high to low so the lowest-index masked bit wins.
        req_cause = '0;
        for (int i = int'(EXC_W) - 1; i >= 0; i--) begin
            if (masked[i]) req_cause = CW'(i + 1);
        end

        do_entry    = req && (state_q != StFault) && (depth_q < DW'(SHADOW_DEPTH));
        do_overflow = req && (state_q != StFault) && (depth_q == DW'(SHADOW_DEPTH));
        do_pop      = trap_return && !req && (state_q == StTrapped);

        popped = '0;
        for (int i = 0; i < int'(SHADOW_DEPTH); i++) begin
            if (depth_q == DW'(i + 1)) popped = stack_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        entry_d  = do_entry;
        cause_d  = do_entry ? req_cause : cause_q;
        dfault_d = dfault_q | do_overflow;
        stack_d  = stack_q;

        if (do_entry) begin
            state_d = StTrapped;
            depth_d = depth_q + DW'(1);
            for (int i = 0; i < int'(SHADOW_DEPTH); i++) begin
                if (depth_q == DW'(i)) stack_d[i] = {exc_q, cond_q};
            end
        end else if (do_overflow) begin
            state_d = StFault;
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
            if (depth_q == DW'(1)) state_d = StNormal;
        end

        if (do_pop) begin
            cond_d = popped[COND_W-1:0];
        end else if (sw_write) begin
            cond_d = sw_wdata[COND_W-1:0];
        end else if (cond_valid) begin
            cond_d = cond_in;
        end else begin
            cond_d = cond_q;
        end

        // Events are always OR'd in so none is lost, whatever the base value.
        if (do_pop) begin
            exc_d = popped[COND_W +: EXC_W] | exc_event;
        end else if (sw_write) begin
            exc_d = sw_wdata[COND_W +: EXC_W] | exc_event;
        end else begin
            exc_d = exc_q | exc_event;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StNormal;
            cond_q   <= '0;
            exc_q    <= '0;
            depth_q  <= '0;
            entry_q  <= 1'b0;
            cause_q  <= '0;
            dfault_q <= 1'b0;
            stack_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cond_q   <= cond_d;
            exc_q    <= exc_d;
            depth_q  <= depth_d;
            entry_q  <= entry_d;
            cause_q  <= cause_d;
            dfault_q <= dfault_d;
            stack_q  <= stack_d;
        end
    end

    assign cond_flags   = cond_q;
    assign exc_flags    = exc_q;
    assign trap_mode    = (state_q != StNormal);
    assign trap_entry   = entry_q;
    assign trap_cause   = cause_q;
    assign trap_depth   = depth_q;
    assign double_fault = dfault_q;

endmodule

// File: doc/status_flag_controller.md
# status_flag_controller

Parametrised successor to the single-level status register. It holds ALU condition flags (replaced on every update) and sticky exception flags (OR-accumulated). A trap FSM saves both flag sets on a shadow stack of configurable depth and restores them on trap return. Nesting past the stack depth latches a double-fault state. The block sits beside the execute stage: it takes ALU condition results and exception event pulses, and drives flag and trap state to the control unit.

## Interface
- `COND_W`, 4: condition flag width; bit order {carry, overflow, sign, zero}, LSB = zero.
- `EXC_W`, 8: exception flag width; bit order {trap_instr_seen, same_register, half_word, memory_corruption, memory_violation, division_by_zero, underflow, overflow_exc}.
- `TRAP_MASK`, 8'h0C (EXC_W bits): exception bits that request a trap.
- `SHADOW_DEPTH`, 4: number of shadow-stack entries; must be ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cond_valid` in 1: load `cond_in` this cycle.
- `cond_in` in COND_W: new condition flags.
- `exc_event` in EXC_W: one-cycle event pulses, OR'd into the sticky flags.
- `trap_instruction` in 1: software trap request pulse.
- `trap_return` in 1: return from the current trap level.
- `sw_write` in 1: software overwrite of both flag sets.
- `sw_wdata` in COND_W+EXC_W: {exc, cond}.
- `cond_flags` out COND_W: live condition flags.
- `exc_flags` out EXC_W: live sticky exception flags.
- `trap_mode` out 1: high when depth > 0 or in FAULT.
- `trap_entry` out 1: one-cycle pulse when a trap is taken.
- `trap_cause` out $clog2(EXC_W+1): 0 = trap_instruction; i+1 = exception bit i.
- `trap_depth` out $clog2(SHADOW_DEPTH+1): current nesting level.
- `double_fault` out 1: stack overflow; clears only on reset.

## Operation
**Trap request**
- req = `trap_instruction` | (|(`exc_event` & TRAP_MASK)).
- Cause priority: lowest-index masked exception bit first; otherwise 0 (trap_instruction).

**FSM states**
- NORMAL (depth 0), TRAPPED (depth 1..SHADOW_DEPTH), FAULT.

**Entry** (req, state ≠ FAULT, depth < SHADOW_DEPTH)
- Push pre-edge {exc_flags, cond_flags} to stack[depth].
- depth++, `trap_entry`=1, `trap_cause` updated.
- Live registers still take this cycle's updates.

**Overflow** (req with depth == SHADOW_DEPTH)
- No push; go to FAULT; `double_fault`=1.
- In FAULT, req and `trap_return` are ignored; flag updates continue. Only reset exits FAULT.

**Return** (`trap_return`, no req, state TRAPPED)
- depth--; cond = popped cond; exc = popped exc | `exc_event`.
- `trap_return` at depth 0 is ignored.

**Simultaneous events**
- req with `trap_return` in the same cycle: req wins; return is dropped.
- cond priority: pop > sw_write > cond_valid > hold.
- exc priority: pop|event > sw_write|event > exc_flags|event. Events are never lost.
- `trap_cause` holds its value until the next entry.
- A held request pushes every cycle; callers drive single-cycle pulses.

## Timing
- All outputs are registered; every effect is visible the cycle after the sampling edge.
- `trap_entry` is high for exactly one cycle per accepted entry.
- `reset_n` low, asynchronously: every output and stack entry goes to 0, FSM goes to NORMAL.
- Reset asserted mid-trap discards all stack contents.
- Reset deassertion is synchronised externally.

## Test plan
- **Reset:** assert `reset_n`=0 mid-trap at depth 2 → all outputs 0 and `trap_mode`=0 immediately, before the next edge.
- **Flag update:** `cond_valid`, `cond_in`=4'b0101, then `exc_event`=8'h01 and then 8'h02 → cond=4'h5; exc=8'h03 and stays 8'h03 after the events drop.
- **Trap and restore:** flags cond=4'h3, exc=8'h00; pulse `trap_instruction` → depth 1, `trap_entry` pulse, cause 0. Handler writes `sw_wdata`=0. `trap_return` with `exc_event`=8'h80 → cond=4'h3, exc=8'h80, depth 0.
- **Cause priority:** `exc_event`=8'h0C with `trap_instruction`=1 → exactly one push, `trap_cause`=3 (bit 2), exc=8'h0C.
- **Overflow:** SHADOW_DEPTH=4; 5 consecutive pulsed traps → depth 4, `double_fault`=1, `trap_mode`=1. Subsequent `trap_return` leaves depth at 4; only reset clears the fault.
- **Simultaneous events:** req with `trap_return` at depth 1 → depth 2 (return dropped). `trap_return` at depth 0 → no change. Pop with `sw_write` in the same cycle → popped values win.
